seq_alu: RTL

Sequential ALU for the RISC-V datapath, and the consumer of the 4-bit `Operation` code emitted by the ALU controller. It accepts an operation and two operands over a valid/ready handshake. Single-cycle ops complete in one cycle; shifts run iteratively, one bit per cycle. It returns the result, a zero flag and an illegal-op flag over a second valid/ready handshake, so the multi-cycle core can stall on long shifts.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_shift_unit.sv | 64 ++++++
 rtl/seq_alu.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Purpose  : Shared ALU operation codes, sequential-ALU FSM states and a      |
// |            small helper used by seq_alu and the ALU controller.            |
// | Contents : ALU_OP_W, alu_op_e, seq_alu_state_e, is_shift_op()              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SUB = 4'b0100,
    OP_SLT = 4'b0101,
    OP_SLL = 4'b0110,
    OP_SRL = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_SRA = 4'b1001,
    OP_BNE = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_alu_state_e;

  function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shift_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_shift_unit                                                  |
// | Purpose  : Iterative one-bit-per-cycle shifter with down-counter.          |
// |            load_i captures data/shamt/op; the unit is busy while the       |
// |            counter is non-zero. done_o flags the final step, whose value   |
// |            is visible on step_o so the owner can capture it directly.      |
// | Ports    : clk, reset (async, active-high), load_i, op_i[3:0],             |
// |            data_i[DATA_WIDTH], shamt_i[SHAMT_W], done_o, step_o[DATA_WIDTH]|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [ALU_OP_W-1:0]   op_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [SHAMT_W-1:0]    shamt_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] step_o
);

  logic [DATA_WIDTH-1:0] shreg_q;
  logic [SHAMT_W-1:0]    cnt_q;
  logic [ALU_OP_W-1:0]   op_q;
  logic                  w_busy;

  assign w_busy = (cnt_q != '0);
  // The step that brings the counter from 1 to 0 is the last one.
  assign done_o = (cnt_q == SHAMT_W'(1));

  // Value of the register after one more shift step.
  always_comb begin
    step_o = shreg_q;
    case (op_q)
      OP_SLL:  step_o = {shreg_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  step_o = {1'b0, shreg_q[DATA_WIDTH-1:1]};
      OP_SRA:  step_o = {shreg_q[DATA_WIDTH-1], shreg_q[DATA_WIDTH-1:1]};
      default: step_o = shreg_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
      cnt_q   <= shamt_i;
      op_q    <= op_i;
    end else if (w_busy) begin
      shreg_q <= step_o;
      cnt_q   <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_alu                                                         |
// | Purpose  : Sequential RISC-V ALU. One request in over in_valid/in_ready,   |
// |            one result out over out_valid/out_ready. Logic ops complete in  |
// |            one cycle; shifts iterate one bit per cycle unless              |
// |            SEQ_ALU_FAST_SHIFT_EN is defined (barrel shifter, 1 cycle).     |
// | Ports    : clk, reset (async, active-high), in_valid, in_ready,            |
// |            Operation[3:0], SrcA, SrcB, out_valid, out_ready, ALUResult,    |
// |            Zero, illegal_op                                                |
// | Macro    : SEQ_ALU_FAST_SHIFT_EN                                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_alu
  import alu_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_OP_W-1:0]   Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  illegal_op
);

  seq_alu_state_e        state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  illegal_q, illegal_d;

  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_illegal;
  logic [SHAMT_W-1:0]    w_shamt;

  assign w_shamt = SrcB[SHAMT_W-1:0];

  // Single-cycle result computed from the live inputs; only used in IDLE.
  always_comb begin
    w_res     = '0;
    w_illegal = 1'b0;
    case (Operation)
      OP_AND: w_res = SrcA & SrcB;
      OP_OR:  w_res = SrcA | SrcB;
      OP_ADD: w_res = SrcA + SrcB;
      OP_XOR: w_res = SrcA ^ SrcB;
      OP_SUB: w_res = SrcA - SrcB;
      OP_SLT: w_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_BEQ: w_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      OP_BNE: w_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
`ifdef SEQ_ALU_FAST_SHIFT_EN
      OP_SLL: w_res = SrcA << w_shamt;
      OP_SRL: w_res = SrcA >> w_shamt;
      OP_SRA: w_res = $signed(SrcA) >>> w_shamt;
`else
      // Only shamt=0 shifts take the single-cycle path: result is SrcA.
      OP_SLL, OP_SRL, OP_SRA: w_res = SrcA;
`endif
      default: w_illegal = 1'b1;
    endcase
  end

`ifndef SEQ_ALU_FAST_SHIFT_EN
  logic                  w_sh_load;
  logic                  w_sh_done;
  logic [DATA_WIDTH-1:0] w_sh_step;

  alu_shift_unit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load_i  (w_sh_load),
    .op_i    (Operation),
    .data_i  (SrcA),
    .shamt_i (w_shamt),
    .done_o  (w_sh_done),
    .step_o  (w_sh_step)
  );
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifndef SEQ_ALU_FAST_SHIFT_EN
    w_sh_load = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifndef SEQ_ALU_FAST_SHIFT_EN
          if (is_shift_op(Operation) && (w_shamt != '0)) begin
            w_sh_load = 1'b1;
            state_d   = SHIFT;
          end else begin
            result_d  = w_res;
            zero_d    = (w_res == '0);
            illegal_d = w_illegal;
            state_d   = DONE;
          end
`else
          result_d  = w_res;
          zero_d    = (w_res == '0);
          illegal_d = w_illegal;
          state_d   = DONE;
`endif
        end
      end
`ifndef SEQ_ALU_FAST_SHIFT_EN
      SHIFT: begin
        // Final step goes straight into the output register.
        if (w_sh_done) begin
          result_d  = w_sh_step;
          zero_d    = (w_sh_step == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign ALUResult  = result_q;
  assign Zero       = zero_q;
  assign illegal_op = illegal_q;

endmodule
`default_nettype wire
